// File: rtl/loader_sdram_bridge.sv
// Queues GameLoader byte writes in a small FIFO and issues one per 4-phase NES slot,
// muxing the SDRAM address/data/write lines between the download path and the NES core.
module loader_sdram_bridge #(
  parameter int         ADDR_W     = 22,
  parameter int         DEPTH_LOG2 = 2,
  parameter logic [1:0] SLOT_PHASE = 2'd3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        ce_phase,
  input  logic              downloading,
  input  logic              ld_write,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_data,
  input  logic [ADDR_W-1:0] nes_addr,
  input  logic              nes_write,
  input  logic [7:0]        nes_dout,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_write,
  output logic [7:0]        mem_din,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W-1:0] bytes_written
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } entry_t;

  entry_t                fifo [DEPTH];
  logic [DEPTH_LOG2-1:0] rd_ptr, wr_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  wr_active;
  logic [ADDR_W-1:0]     wr_addr;
  logic [7:0]            wr_data;
  logic                  downloading_q;

  logic slot, rise, fall, empty, full, push, pop, accept;

  always_comb begin
    slot   = (ce_phase == SLOT_PHASE);
    rise   = downloading & ~downloading_q;
    fall   = ~downloading & downloading_q;
    empty  = (count == '0);
    full   = (count == (DEPTH_LOG2 + 1)'(DEPTH));
    pop    = slot & ~empty & ~fall;
    push   = downloading & ld_write;
    // A full FIFO still accepts on a pop edge: the head leaves as the new byte enters.
    accept = push & (~full | pop);
  end

  // NOTE: entry storage carries no reset; count alone decides which entries are valid.
  always_ff @(posedge clk) begin
    if (accept) fifo[wr_ptr] <= '{addr: ld_addr, data: ld_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr        <= '0;
      wr_ptr        <= '0;
      count         <= '0;
      wr_active     <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      downloading_q <= 1'b0;
      overflow      <= 1'b0;
      bytes_written <= '0;
    end else begin
      downloading_q <= downloading;
      if (fall) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        count     <= '0;
        wr_active <= 1'b0;
      end else begin
        if (slot) wr_active <= ~empty;
        if (pop) begin
          wr_addr <= fifo[rd_ptr].addr;
          wr_data <= fifo[rd_ptr].data;
          rd_ptr  <= rd_ptr + 1'b1;
        end
        if (accept) wr_ptr <= wr_ptr + 1'b1;
        case ({accept, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
      // Counters are held across a download's end and cleared only when the next begins.
      if (rise) begin
        bytes_written <= '0;
        overflow      <= 1'b0;
      end else begin
        if (pop && !(&bytes_written)) bytes_written <= bytes_written + 1'b1;
        if (push && !accept)          overflow      <= 1'b1;
      end
    end
  end

  always_comb begin
    mem_write = downloading ? wr_active : nes_write;
    mem_addr  = downloading ? wr_addr   : nes_addr;
    mem_din   = downloading ? wr_data   : nes_dout;
    busy      = ~empty | wr_active;
  end

endmodule

// File: tb/tb_loader_sdram_bridge.sv
// Bench for loader_sdram_bridge: directed scenarios plus randomized traffic, every cycle
// compared against a queue-based model of the download bridge.
module tb_loader_sdram_bridge;

  logic        clk = 1'b0;
  logic        reset, downloading, ld_write, nes_write;
  logic [1:0]  ce_phase = 2'd0;
  logic [21:0] ld_addr, nes_addr, mem_addr, bytes_written;
  logic [7:0]  ld_data, nes_dout, mem_din;
  logic        mem_write, busy, overflow;

  loader_sdram_bridge dut (
    .clk(clk), .reset(reset), .ce_phase(ce_phase), .downloading(downloading),
    .ld_write(ld_write), .ld_addr(ld_addr), .ld_data(ld_data),
    .nes_addr(nes_addr), .nes_write(nes_write), .nes_dout(nes_dout),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_din(mem_din),
    .busy(busy), .overflow(overflow), .bytes_written(bytes_written)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: pending bytes as a queue, plus the write currently presented.
  typedef struct {
    logic [21:0] a;
    logic [7:0]  d;
  } ent_t;

  ent_t        mq[$];
  logic        m_act = 1'b0, m_dl = 1'b0, m_ov = 1'b0;
  logic [21:0] m_addr = '0, m_bw = '0;
  logic [7:0]  m_data = '0;

  task automatic model_edge();
    ent_t e;
    if (reset) begin
      mq.delete();
      m_act = 1'b0; m_addr = '0; m_data = '0; m_bw = '0; m_ov = 1'b0; m_dl = 1'b0;
    end else begin
      if (downloading && !m_dl) begin
        m_bw = '0;
        m_ov = 1'b0;
      end
      if (!downloading && m_dl) begin
        mq.delete();
        m_act = 1'b0;
      end else begin
        if (ce_phase == 2'd3) begin
          if (mq.size() > 0) begin
            e = mq.pop_front();
            m_addr = e.a;
            m_data = e.d;
            m_act  = 1'b1;
            if (m_bw != 22'h3FFFFF) m_bw = m_bw + 22'd1;
          end else begin
            m_act = 1'b0;
          end
        end
        if (downloading && ld_write) begin
          if (mq.size() < 4) mq.push_back('{a: ld_addr, d: ld_data});
          else m_ov = 1'b1;
        end
      end
      m_dl = downloading;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    ce_phase = ce_phase + 2'd1;
    check("mem_write", 32'(mem_write), 32'(downloading ? m_act : nes_write));
    check("mem_addr", 32'(mem_addr), 32'(downloading ? m_addr : nes_addr));
    check("mem_din", 32'(mem_din), 32'(downloading ? m_data : nes_dout));
    check("busy", 32'(busy), 32'((mq.size() > 0) || m_act));
    check("overflow", 32'(overflow), 32'(m_ov));
    check("bytes_written", 32'(bytes_written), 32'(m_bw));
  endtask

  task automatic align0();
    while (ce_phase != 2'd0) tick();
  endtask

  task automatic new_download();
    downloading = 1'b0;
    ld_write    = 1'b0;
    tick();
    downloading = 1'b1;
    tick();
    check("nd_bytes_zero", 32'(bytes_written), 32'd0);
    check("nd_ovf_zero", 32'(overflow), 32'd0);
  endtask

  logic [21:0] got_q[$];
  int          hi, rises;
  logic        prev;

  initial begin
    reset = 1'b1; downloading = 1'b0; ld_write = 1'b0; ld_addr = '0; ld_data = '0;
    nes_addr = '0; nes_write = 1'b0; nes_dout = '0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bytes", 32'(bytes_written), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // T1: single byte pushed at phase 0, issued at the phase-3 edge for 4 clocks
    new_download();
    align0();
    ld_write = 1'b1; ld_addr = 22'h000010; ld_data = 8'hA5;
    tick();
    ld_write = 1'b0;
    tick();
    tick();
    check("t1_not_yet", 32'(mem_write), 32'd0);
    tick();
    check("t1_we", 32'(mem_write), 32'd1);
    check("t1_addr", 32'(mem_addr), 32'h10);
    check("t1_din", 32'(mem_din), 32'hA5);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t1_hold", 32'(mem_write), 32'd1);
    end
    tick();
    check("t1_end_we", 32'(mem_write), 32'd0);
    check("t1_bytes", 32'(bytes_written), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);

    // T2: four back-to-back writes -> four contiguous slots
    new_download();
    align0();
    got_q.delete(); hi = 0; rises = 0; prev = 1'b0;
    for (int i = 0; i < 24; i++) begin
      ld_write = (i < 4);
      ld_addr  = 22'h100 + 22'(i);
      ld_data  = 8'(8'h11 * (i + 1));
      tick();
      if (mem_write) hi++;
      if (mem_write && !prev) rises++;
      prev = mem_write;
      if (ce_phase == 2'd0 && mem_write) got_q.push_back(mem_addr);
    end
    ld_write = 1'b0;
    check("t2_high_clocks", 32'(hi), 32'd16);
    check("t2_one_burst", 32'(rises), 32'd1);
    check("t2_issued", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check("t2_order", 32'(got_q[i]), 32'h100 + 32'(i));
    check("t2_bytes", 32'(bytes_written), 32'd4);
    check("t2_ovf", 32'(overflow), 32'd0);

    // T3: seven consecutive writes -> 6th and 7th dropped
    new_download();
    align0();
    got_q.delete();
    for (int i = 0; i < 28; i++) begin
      ld_write = (i < 7);
      ld_addr  = 22'h200 + 22'(i);
      ld_data  = 8'(i + 1);
      tick();
      if (ce_phase == 2'd0 && mem_write) got_q.push_back(mem_addr);
    end
    ld_write = 1'b0;
    check("t3_issued", 32'(got_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < got_q.size(); i++)
      check("t3_order", 32'(got_q[i]), 32'h200 + 32'(i));
    check("t3_ovf", 32'(overflow), 32'd1);
    check("t3_bytes", 32'(bytes_written), 32'd5);

    // T4: NES owns the bus when not downloading; stray loader strobe ignored
    downloading = 1'b0;
    tick();
    nes_write = 1'b1; nes_addr = 22'h2ABCD; nes_dout = 8'h7E; ld_write = 1'b1;
    #1;
    check("t4_we", 32'(mem_write), 32'd1);
    check("t4_addr", 32'(mem_addr), 32'h2ABCD);
    check("t4_din", 32'(mem_din), 32'h7E);
    tick();
    check("t4_busy", 32'(busy), 32'd0);
    ld_write = 1'b0; nes_write = 1'b0; nes_addr = '0; nes_dout = '0;

    // T5: reset with three entries pending discards them
    new_download();
    align0();
    for (int i = 0; i < 3; i++) begin
      ld_write = 1'b1; ld_addr = 22'h300 + 22'(i); ld_data = 8'(8'hC0 + i);
      tick();
    end
    ld_write = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_we", 32'(mem_write), 32'd0);
    check("t5_bytes", 32'(bytes_written), 32'd0);
    check("t5_ovf", 32'(overflow), 32'd0);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mem_write) hi++;
    end
    check("t5_no_ghost", 32'(hi), 32'd0);

    // T6: downloading falls with entries queued -> flush, counters held, cleared on rise
    new_download();
    align0();
    for (int i = 0; i < 2; i++) begin
      ld_write = 1'b1; ld_addr = 22'h400 + 22'(i); ld_data = 8'(8'hD0 + i);
      tick();
    end
    ld_write = 1'b0;
    tick();
    tick();
    check("t6_issuing", 32'(mem_write), 32'd1);
    downloading = 1'b0;
    tick();
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_we_nes", 32'(mem_write), 32'd0);
    check("t6_bytes_hold", 32'(bytes_written), 32'd1);
    downloading = 1'b1;
    tick();
    check("t6_bytes_clr", 32'(bytes_written), 32'd0);
    check("t6_ovf_clr", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) tick();
    check("t6_flushed", 32'(busy), 32'd0);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) downloading = ~downloading;
      reset     = ($urandom_range(0, 299) == 0);
      ld_write  = ($urandom_range(0, 2) == 0);
      ld_addr   = 22'($urandom);
      ld_data   = 8'($urandom);
      nes_write = 1'($urandom);
      nes_addr  = 22'($urandom);
      nes_dout  = 8'($urandom);
      tick();
    end
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
